// File: rtl/noc_pkg.sv
// Shared router definitions: direction codes, one-hot port indices, flit width.
// Latency: none (constants and a pure combinational helper).
// Backpressure: not applicable.
package noc_pkg;

   localparam int DATASIZE_DEF = 40;

   // Direction codes carried alongside each flit
   localparam logic [3:0] DIR_N = 4'd0;
   localparam logic [3:0] DIR_E = 4'd1;
   localparam logic [3:0] DIR_W = 4'd2;
   localparam logic [3:0] DIR_S = 4'd3;
   localparam logic [3:0] DIR_L = 4'd4;

   // Bit positions in the one-hot output-port request {L,S,W,E,N}
   localparam int PORT_N = 0;
   localparam int PORT_E = 1;
   localparam int PORT_W = 2;
   localparam int PORT_S = 3;
   localparam int PORT_L = 4;

   // Map a direction code to its one-hot port request; illegal codes request nothing
   function automatic logic [4:0] dir_onehot(input logic [3:0] dir);
      logic [4:0] oh;
      oh = 5'b0;
      case (dir)
         DIR_N:   oh[PORT_N] = 1'b1;
         DIR_E:   oh[PORT_E] = 1'b1;
         DIR_W:   oh[PORT_W] = 1'b1;
         DIR_S:   oh[PORT_S] = 1'b1;
         DIR_L:   oh[PORT_L] = 1'b1;
         default: oh = 5'b0;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/infifo_ram.sv
// Storage for the input FIFO: DEPTH x WIDTH registers, one write port, one async read port.
// Latency: write lands on the clock edge; read is combinational from the address.
// Backpressure: none here; the owner decides when a write is legal.
module infifo_ram #(
   parameter int WIDTH = 44,
   parameter int DEPTH = 4,
   parameter int ADDRW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [ADDRW-1:0] waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [ADDRW-1:0] raddr,
   output logic [WIDTH-1:0] rdata
);

   // Contents are deliberately not reset: stale entries are never visible while empty
   logic [WIDTH-1:0] mem [DEPTH];

   // Capture the entry on an accepted write
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/port_infifo.sv
// Per-port FWFT input buffer: stores flit+direction, presents head with one-hot port request.
// Latency: a write at edge k is visible on rdata/rdir/req after edge k; pop likewise 1 edge.
// Backpressure: wfull stalls route computation; writes while full are dropped and flagged.
module port_infifo
   import noc_pkg::*;
#(
   parameter int DATASIZE = DATASIZE_DEF,
   parameter int DEPTH    = 4,
   parameter int ADDRW    = $clog2(DEPTH)
) (
   input  logic                rc_clk,
   input  logic                rst_n,
   input  logic                winc,
   input  logic [DATASIZE-1:0] wdata,
   input  logic [3:0]          wdir,
   output logic                wfull,
   output logic                rvalid,
   output logic [DATASIZE-1:0] rdata,
   output logic [3:0]          rdir,
   output logic [4:0]          req,
   input  logic                rready,
   output logic [ADDRW:0]      count,
   output logic                ovf_err,
   output logic                dir_err
);

   // Pointers carry an extra wrap bit so full and empty are distinguishable
   logic [ADDRW:0]          wptr;
   logic [ADDRW:0]          rptr;
   logic                    empty;
   logic                    push;
   logic                    pop;
   logic [DATASIZE+3:0]     head;

   // Full/empty come only from registered pointers, never from this cycle's strobes
   assign empty  = (wptr == rptr);
   assign wfull  = (wptr[ADDRW-1:0] == rptr[ADDRW-1:0]) && (wptr[ADDRW] != rptr[ADDRW]);
   assign count  = wptr - rptr;
   assign rvalid = ~empty;

   // A pop in the same cycle does not make room for a write: wfull is judged first
   assign push = winc & ~wfull;
   assign pop  = rvalid & rready;

   infifo_ram #(
      .WIDTH (DATASIZE + 4),
      .DEPTH (DEPTH),
      .ADDRW (ADDRW)
   ) u_ram (
      .clk   (rc_clk),
      .we    (push),
      .waddr (wptr[ADDRW-1:0]),
      .wdata ({wdir, wdata}),
      .raddr (rptr[ADDRW-1:0]),
      .rdata (head)
   );

   assign rdir  = head[DATASIZE+3:DATASIZE];
   assign rdata = head[DATASIZE-1:0];

   // Request is gated by rvalid so an empty FIFO never asks the allocator for a port
   assign req = rvalid ? dir_onehot(rdir) : 5'b0;

   // Advance pointers and latch sticky error flags
   always_ff @(posedge rc_clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr    <= '0;
         rptr    <= '0;
         ovf_err <= 1'b0;
         dir_err <= 1'b0;
      end else begin
         if (push) begin
            wptr <= wptr + 1'b1;
         end
         if (pop) begin
            rptr <= rptr + 1'b1;
         end
         if (winc && wfull) begin
            ovf_err <= 1'b1;
         end
         if (push && (wdir > DIR_L)) begin
            dir_err <= 1'b1;
         end
      end
   end

endmodule
